// File: rtl/decrypt.sv
// ----------------------------------------------------------------------------
// decrypt -- LWE decryption core.
//
// Computes the inner product <a, s> mod q with a single multiplier, one
// element per clock. It then forms v = (b - <a,s>) mod q and rounds v to the
// nearest multiple of q/p to recover the plaintext.
//
// Parameters
//   PLAINTEXT_MODULUS  p, power of two
//   PLAINTEXT_WIDTH    log2(p)
//   CIPHERTEXT_MODULUS q, power of two, q > p
//   CIPHERTEXT_WIDTH   log2(q)
//   DIMENSION          n, LWE secret dimension (n >= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request; accepted only while ready is high
//   ready      high only while idle
//   ciphertext {a[n], ..., a[1], b}, b in the LSBs
//   secretkey  {s[n], ..., s[1]}, s[1] in the LSBs
//   plaintext  decoded message, valid while out_valid is high
//   out_valid  result pending; held until out_ready is seen
//   out_ready  consumer accepts the plaintext
//
// Timing: request accepted on edge E0. Edges E1..En accumulate the products,
// edge En+1 registers the result and raises out_valid (n+1 edges of latency).
// ----------------------------------------------------------------------------
module decrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  output logic                                      ready,
  input  logic [(DIMENSION+1)*CIPHERTEXT_WIDTH-1:0] ciphertext,
  input  logic [DIMENSION*CIPHERTEXT_WIDTH-1:0]     secretkey,
  output logic [PLAINTEXT_WIDTH-1:0]                plaintext,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  localparam int CW    = CIPHERTEXT_WIDTH;
  localparam int PW    = PLAINTEXT_WIDTH;
  localparam int IDX_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  // Rounding offset: half of one plaintext step, q/(2p).
  localparam int HALF  = CIPHERTEXT_MODULUS / (2 * PLAINTEXT_MODULUS);
  localparam int SHIFT = CW - PW;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSION - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                             r_state;
  logic [(DIMENSION+1)*CW-1:0]            r_ct;
  logic [DIMENSION*CW-1:0]                r_sk;
  logic [CW-1:0]                          r_acc;
  logic [IDX_W-1:0]                       r_idx;
  logic [PW-1:0]                          r_plaintext;
  logic                                   r_out_valid;

  logic                                   w_accept;
  logic [CW-1:0]                          w_a;
  logic [CW-1:0]                          w_s;
  logic [CW-1:0]                          w_prod;
  logic [CW-1:0]                          w_b;
  logic [CW-1:0]                          w_v;
  logic [CW:0]                            w_round;
  logic [PW-1:0]                          w_plain;

  assign ready     = (r_state == S_IDLE);
  assign w_accept  = ready && start;
  assign plaintext = r_plaintext;
  assign out_valid = r_out_valid;

  // Operand select for the single shared multiplier: element r_idx+1 of a
  // pairs with element r_idx of s, since a is offset by b in the LSBs.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_a = '0;
    w_s = '0;
    for (int k = 0; k < DIMENSION; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a = r_ct[(k+1)*CW +: CW];
        w_s = r_sk[k*CW +: CW];
      end
    end
  end

  // Only the low CW bits matter: everything is reduced mod q, and q is a
  // power of two.
  assign w_prod = w_a * w_s;

  // Decode: wrap-around subtraction, then add half a step one bit wider so
  // the carry out of the top survives. Truncating the shifted value to PW
  // bits makes a round-up past p-1 wrap to 0.
  assign w_b     = r_ct[CW-1:0];
  assign w_v     = w_b - r_acc;
  assign w_round = {1'b0, w_v} + (CW+1)'(HALF);
  assign w_plain = PW'(w_round >> SHIFT);

  // Operand capture. These registers are only read after a request has been
  // accepted, so they need no reset value.
  // NOTE: datapath-only storage is deliberately left out of reset; only
  // control state and the visible outputs are reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_ct <= ciphertext;
      r_sk <= secretkey;
    end
  end

  // Control FSM and accumulator. The reset branch comes first, so reset
  // overrides start and out_ready on the same edge.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_idx       <= '0;
      r_plaintext <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_state <= S_MAC;
          end
        end

        S_MAC: begin
          r_acc <= r_acc + w_prod;
          if (r_idx == LAST_IDX) begin
            r_state <= S_DECODE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        S_DECODE: begin
          r_plaintext <= w_plain;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          // A start during this handshake is not accepted: ready is low here.
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decrypt.sv
// ----------------------------------------------------------------------------
// tb_decrypt -- self-checking bench for decrypt with default parameters.
// Results are checked against an arithmetic reference model of LWE
// decryption.
// ----------------------------------------------------------------------------
module tb_decrypt;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int PW = 6;
  localparam int Q  = 1024;
  localparam int P  = 64;
  localparam int LATENCY = N + 1;
  localparam int BUDGET  = 40;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 ready;
  logic [(N+1)*W-1:0]   ciphertext;
  logic [N*W-1:0]       secretkey;
  logic [PW-1:0]        plaintext;
  logic                 out_valid;
  logic                 out_ready;

  int n_compared;
  int n_mismatched;

  decrypt dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .ciphertext (ciphertext),
    .secretkey  (secretkey),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [N*W-1:0] A_DIR = {10'd4, 10'd3, 10'd2, 10'd1};
  localparam logic [N*W-1:0] S_DIR = {10'd40, 10'd30, 10'd20, 10'd10};

  // Reference: plaintext = round(((b - <a,s>) mod q) / (q/p)) mod p.
  function automatic logic [PW-1:0] model(input int b,
                                          input logic [N*W-1:0] a,
                                          input logic [N*W-1:0] s);
    longint acc;
    longint v;
    longint m;
    acc = 0;
    for (int i = 0; i < N; i++)
      acc += longint'(a[i*W +: W]) * longint'(s[i*W +: W]);
    v = ((longint'(b) - acc) % Q + Q) % Q;
    m = ((v + Q / (2 * P)) / (Q / P)) % P;
    return PW'(m);
  endfunction

  // Drives one request, scrambles the inputs after acceptance and waits
  // (bounded) for out_valid. Leaves the DUT in DONE unless rdy is 1.
  task automatic do_request(input logic [W-1:0] b,
                            input logic [N*W-1:0] a,
                            input logic [N*W-1:0] s,
                            input bit rdy,
                            output int lat,
                            output logic [PW-1:0] pt,
                            output bit timeout);
    @(negedge clk);
    ciphertext = {a, b};
    secretkey  = s;
    out_ready  = rdy;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    ciphertext = {$urandom, $urandom};
    secretkey  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < BUDGET) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    timeout = !out_valid;
    pt = plaintext;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (ready !== 1'b1 || out_valid !== 1'b0 || plaintext !== '0) begin
      n_mismatched++;
      $display("FAIL reset_state: ready=%b out_valid=%b plaintext=%0d, want 1 0 0",
               ready, out_valid, plaintext);
    end
    rst_n = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W-1:0]  bs  [4] = '{10'd383, 10'd220, 10'd296, 10'd0};
    logic [PW-1:0] exp [4] = '{6'd5, 6'd59, 6'd0, 6'd0};
    int lat;
    logic [PW-1:0] pt;
    bit to;
    for (int i = 0; i < 4; i++) begin
      do_request(bs[i], (i == 3) ? '0 : A_DIR, (i == 3) ? '0 : S_DIR,
                 (i == 0), lat, pt, to);
      n_compared++;
      if (to || lat != LATENCY) begin
        n_mismatched++;
        $display("FAIL vec%0d_latency: got %0d edges (timeout=%0b), want %0d",
                 i, lat, to, LATENCY);
      end
      n_compared++;
      if (pt !== exp[i]) begin
        n_mismatched++;
        $display("FAIL vec%0d_plaintext: got %0d, want %0d", i, pt, exp[i]);
      end
      handshake();
      n_compared++;
      if (ready !== 1'b1 || out_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL vec%0d_return_idle: ready=%b out_valid=%b, want 1 0",
                 i, ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [PW-1:0] pt;
    bit to;
    int bad;
    do_request(10'd383, A_DIR, S_DIR, 1'b0, lat, pt, to);
    n_compared++;
    if (to || pt !== 6'd5) begin
      n_mismatched++;
      $display("FAIL bp_result: got %0d (timeout=%0b), want 5", pt, to);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 4);
      ciphertext = {$urandom, $urandom};
      if (out_valid !== 1'b1 || plaintext !== 6'd5 || ready !== 1'b0) bad++;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    n_compared++;
    if (bad != 0) begin
      n_mismatched++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    // Handshake with start asserted on the same edge: must not be accepted.
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (ready !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL bp_release: ready=%b out_valid=%b, want 1 0", ready, out_valid);
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mac();
    int lat;
    logic [PW-1:0] pt;
    bit to;
    int bad;
    @(negedge clk);
    ciphertext = {A_DIR, 10'd383};
    secretkey  = S_DIR;
    start = 1'b1;
    @(posedge clk);            // E0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);            // E1
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);            // E2: reset edge
    @(negedge clk);
    rst_n = 1'b1;
    n_compared++;
    if (out_valid !== 1'b0 || ready !== 1'b1) begin
      n_mismatched++;
      $display("FAIL midmac_reset: out_valid=%b ready=%b, want 0 1", out_valid, ready);
    end
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++;
      $display("FAIL midmac_stale: out_valid high in %0d cycles, want 0", bad);
    end
    do_request(10'd383, A_DIR, S_DIR, 1'b1, lat, pt, to);
    n_compared++;
    if (to || pt !== 6'd5 || lat != LATENCY) begin
      n_mismatched++;
      $display("FAIL midmac_rerun: got pt=%0d lat=%0d, want 5 %0d", pt, lat, LATENCY);
    end
    handshake();
  endtask

  task automatic test_reset_in_done();
    int lat;
    logic [PW-1:0] pt;
    bit to;
    do_request(10'd383, A_DIR, S_DIR, 1'b0, lat, pt, to);
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    n_compared++;
    if (out_valid !== 1'b0 || ready !== 1'b1 || plaintext !== '0) begin
      n_mismatched++;
      $display("FAIL done_reset: out_valid=%b ready=%b plaintext=%0d, want 0 1 0",
               out_valid, ready, plaintext);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [PW-1:0] pt;
    logic [PW-1:0] exp;
    bit to;
    logic [W-1:0] b;
    logic [N*W-1:0] a;
    logic [N*W-1:0] s;
    for (int t = 0; t < 25; t++) begin
      b = W'($urandom);
      a = {$urandom, $urandom};
      s = {$urandom, $urandom};
      exp = model(int'(b), a, s);
      do_request(b, a, s, bit'($urandom_range(0, 1)), lat, pt, to);
      n_compared++;
      if (to || lat != LATENCY || pt !== exp) begin
        n_mismatched++;
        $display("FAIL rand%0d: got pt=%0d lat=%0d, want pt=%0d lat=%0d",
                 t, pt, lat, exp, LATENCY);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
      n_compared++;
      if (ready !== 1'b1) begin
        n_mismatched++;
        $display("FAIL rand%0d_idle: ready=%b, want 1", t, ready);
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    secretkey  = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_mac();
    test_reset_in_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
